sar_seq_ctrl: RTL and testbench
===============================

SAR_SEQ_CTRL -- requirements
Module: sar_seq_ctrl

Interface
REQ-001 Parameter DATA, default 8, conversion result width in bits (DATA >= 2).
REQ-002 Parameter CH, default 4, number of analog input channels (CH >= 1).
REQ-003 Parameter CHW, default 2, channel index width; CH <= 2**CHW SHALL hold.
REQ-004 Parameter SAMPLE_CYC, default 2, number of sample/track cycles per conversion (>= 1).
REQ-005 Clock input 1: all state changes on rising edge.
REQ-006 Reset input 1: asynchronous, active-high.
REQ-007 Start input 1: request a conversion, or a scan when Scan=1; sampled only in IDLE.
REQ-008 Scan input 1: sampled with Start; 1 = convert channels 0..CH-1 in order, 0 = convert ChSel only.
REQ-009 ChSel input CHW: channel for single mode; sampled with Start.
REQ-010 Abort input 1: cancel any activity.
REQ-011 Compare input 1: comparator result for the current trial; 1 = analog input >= DacCode.
REQ-012 SampleEn output 1: track/hold switch enable; high only in SAMPLE.
REQ-013 ChAddr output CHW: analog mux select for the channel in progress.
REQ-014 DacCode output DATA: trial code driven to the DAC.
REQ-015 Busy output 1: high in every state except IDLE.
REQ-016 Valid output 1: one-cycle result strobe.
REQ-017 DataOut output DATA: last completed result; held between strobes.
REQ-018 ChOut output CHW: channel of DataOut; held between strobes.

Function
REQ-019 States SHALL be IDLE, SAMPLE, CONVERT and DONE, all registered.
REQ-020 IDLE + Start=1 -> SAMPLE next cycle; latch Scan; ChAddr <= (Scan ? 0 : ChSel).
REQ-021 ChSel >= CH in single mode SHALL be accepted and ChAddr SHALL be forced to CH-1.
REQ-022 SAMPLE SHALL last exactly SAMPLE_CYC cycles (internal counter), then go to CONVERT.
REQ-023 On CONVERT entry: result register = 0, trial bit = MSB.
REQ-024 In CONVERT, DacCode SHALL equal result | trial bit; outside CONVERT, DacCode SHALL be 0.
REQ-025 On each CONVERT cycle, Compare=1 SHALL set the current trial bit in the result; trial bit SHALL then shift right by one.
REQ-026 CONVERT SHALL last exactly DATA cycles; the cycle on which the LSB is evaluated -> DONE.
REQ-027 DONE SHALL last one cycle: Valid=1, DataOut = final result, ChOut = ChAddr, updated on the same edge as DONE entry.
REQ-028 DONE -> IDLE in single mode, and in scan mode when ChAddr = CH-1.
REQ-029 DONE -> SAMPLE in scan mode when ChAddr < CH-1, with ChAddr incremented; no idle cycle between channels.
REQ-030 Latency Start -> Valid SHALL be 1 + SAMPLE_CYC + DATA cycles per channel; a full scan SHALL take CH*(SAMPLE_CYC+DATA+1) cycles.
REQ-031 Start while Busy=1 SHALL be ignored, with no queuing.
REQ-032 Abort=1 in any non-IDLE state -> IDLE next cycle: no Valid, DataOut/ChOut unchanged, partial result discarded.
REQ-033 Abort and Start both high in IDLE: Abort SHALL win; stay IDLE.
REQ-034 Compare SHALL be ignored outside CONVERT.

Reset
REQ-035 Reset=1 -> IDLE immediately: SampleEn=0, Busy=0, Valid=0, DacCode=0, DataOut=0, ChOut=0, ChAddr=0, internal counters/result cleared.
REQ-036 Reset asserted mid-conversion or mid-scan SHALL discard all progress; the first action after release SHALL be a fresh Start.

Verification
REQ-037 DATA=8, single, ChSel=2, comparator model input=0xA5 -> Valid after 11 cycles, DataOut=0xA5, ChOut=2, DacCode trials 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5.
REQ-038 Scan, CH=4, inputs 0x00/0xFF/0x80/0x7F -> four Valid pulses 11 cycles apart, results in order with ChOut=0,1,2,3, then Busy=0.
REQ-039 Abort during the 4th CONVERT cycle of channel 1 in a scan -> IDLE next cycle, no further Valid, DataOut still holds the channel-0 result.
REQ-040 Start pulsed every cycle while Busy -> exactly one conversion; an extra Start one cycle after DONE starts a new conversion.
REQ-041 Reset asserted in SAMPLE and in CONVERT -> all outputs at reset values asynchronously (before the next edge); ChSel=7 with CH=4 -> ChAddr=3.

Source files
------------

// File: rtl/sar_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sar_seq_ctrl_if
// Description : Bundle of the SAR sequencer control/data signals.
//               master modport : host/analog front-end side (drives requests
//                                and the comparator result)
//               slave modport  : sequencer side (sar_seq_ctrl)
//   Start   - request a conversion (or a scan when Scan=1)
//   Scan    - 1: convert channels 0..CH-1, 0: convert ChSel only
//   ChSel   - channel for single mode
//   Abort   - cancel any activity
//   Compare - comparator result, 1 = analog input >= DacCode
//   SampleEn- track/hold switch enable
//   ChAddr  - analog mux select
//   DacCode - trial code to the DAC
//   Busy    - sequencer not idle
//   Valid   - one-cycle result strobe
//   DataOut - last completed result
//   ChOut   - channel of DataOut
// Revision    : 1.0 - initial release
// ============================================================================
interface sar_seq_ctrl_if #(
  parameter int DATA = 8,
  parameter int CHW  = 2
);
  logic            Start;
  logic            Scan;
  logic [CHW-1:0]  ChSel;
  logic            Abort;
  logic            Compare;
  logic            SampleEn;
  logic [CHW-1:0]  ChAddr;
  logic [DATA-1:0] DacCode;
  logic            Busy;
  logic            Valid;
  logic [DATA-1:0] DataOut;
  logic [CHW-1:0]  ChOut;

  modport master (
    output Start, Scan, ChSel, Abort, Compare,
    input  SampleEn, ChAddr, DacCode, Busy, Valid, DataOut, ChOut
  );

  modport slave (
    input  Start, Scan, ChSel, Abort, Compare,
    output SampleEn, ChAddr, DacCode, Busy, Valid, DataOut, ChOut
  );
endinterface
`default_nettype wire

// File: rtl/sar_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sar_seq_ctrl
// Description : Successive-approximation ADC sequencer. Samples a channel for
//               SAMPLE_CYC cycles, runs DATA binary-search trials against the
//               comparator, then strobes the result. Optionally scans all
//               channels back to back.
//   Clock  - rising-edge clock
//   Reset  - asynchronous, active-high reset
//   bus    - sar_seq_ctrl_if.slave (request, comparator and result signals)
// Revision    : 1.0 - initial release
// ============================================================================
module sar_seq_ctrl #(
  parameter int DATA       = 8,
  parameter int CH         = 4,
  parameter int CHW        = 2,
  parameter int SAMPLE_CYC = 2
) (
  input  logic               Clock,
  input  logic               Reset,
  sar_seq_ctrl_if.slave      bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SAMPLE  = 2'd1;
  localparam logic [1:0] S_CONVERT = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam int              CNTW        = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;
  localparam logic [CNTW-1:0] SAMPLE_LAST = CNTW'(SAMPLE_CYC - 1);
  localparam logic [CHW-1:0]  CH_LAST     = CHW'(CH - 1);
  localparam logic [CHW-1:0]  CH_ONE      = CHW'(1);
  localparam logic [DATA-1:0] TRIAL_MSB   = {1'b1, {(DATA-1){1'b0}}};

  logic [1:0]      state_q,   state_d;
  logic            scan_q,    scan_d;
  logic [CHW-1:0]  chaddr_q,  chaddr_d;
  logic [CNTW-1:0] cnt_q,     cnt_d;
  logic [DATA-1:0] result_q,  result_d;
  logic [DATA-1:0] trial_q,   trial_d;
  logic [DATA-1:0] dataout_q, dataout_d;
  logic [CHW-1:0]  chout_q,   chout_d;

  logic [CHW-1:0]  w_sel_clamped;
  logic [DATA-1:0] w_result_upd;
  logic            w_scan_more;

  // Out-of-range single-mode selects land on the last real channel.
  assign w_sel_clamped = (bus.ChSel > CH_LAST) ? CH_LAST : bus.ChSel;
  // Result with the current trial bit kept when the comparator says input >= code.
  assign w_result_upd  = result_q | (bus.Compare ? trial_q : '0);
  assign w_scan_more   = scan_q && (chaddr_q != CH_LAST);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.Start && !bus.Abort) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (bus.Abort)                 state_d = S_IDLE;
        else if (cnt_q == SAMPLE_LAST) state_d = S_CONVERT;
      end
      S_CONVERT: begin
        // trial_q[0] marks the LSB trial, i.e. the last CONVERT cycle.
        if (bus.Abort)       state_d = S_IDLE;
        else if (trial_q[0]) state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.Abort)        state_d = S_IDLE;
        else if (w_scan_more) state_d = S_SAMPLE;
        else                  state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath next values
  // --------------------------------------------------------------------------
  always_comb begin
    scan_d    = scan_q;
    chaddr_d  = chaddr_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    trial_d   = trial_q;
    dataout_d = dataout_q;
    chout_d   = chout_q;

    if (state_q != S_IDLE && bus.Abort) begin
      // Partial progress is dropped; published result stays untouched.
      cnt_d    = '0;
      result_d = '0;
      trial_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.Start && !bus.Abort) begin
            scan_d   = bus.Scan;
            chaddr_d = bus.Scan ? '0 : w_sel_clamped;
            cnt_d    = '0;
          end
        end
        S_SAMPLE: begin
          if (cnt_q == SAMPLE_LAST) begin
            cnt_d    = '0;
            result_d = '0;
            trial_d  = TRIAL_MSB;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_CONVERT: begin
          result_d = w_result_upd;
          trial_d  = trial_q >> 1;
          if (trial_q[0]) begin
            // Publish on the edge that enters DONE so Valid and data align.
            dataout_d = w_result_upd;
            chout_d   = chaddr_q;
          end
        end
        S_DONE: begin
          if (w_scan_more) begin
            chaddr_d = chaddr_q + CH_ONE;
            cnt_d    = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      scan_q    <= 1'b0;
      chaddr_q  <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      trial_q   <= '0;
      dataout_q <= '0;
      chout_q   <= '0;
    end else begin
      scan_q    <= scan_d;
      chaddr_q  <= chaddr_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      trial_q   <= trial_d;
      dataout_q <= dataout_d;
      chout_q   <= chout_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    bus.SampleEn = (state_q == S_SAMPLE);
    bus.Busy     = (state_q != S_IDLE);
    bus.Valid    = (state_q == S_DONE);
    bus.DacCode  = (state_q == S_CONVERT) ? (result_q | trial_q) : '0;
    bus.ChAddr   = chaddr_q;
    bus.DataOut  = dataout_q;
    bus.ChOut    = chout_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_sar_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sar_seq_ctrl
// Description : Scoreboard bench for sar_seq_ctrl. A comparator model drives
//               Compare from per-channel analog values; directed sequences push
//               expected results, a monitor pops them on every Valid strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sar_seq_ctrl;

  localparam int DATA = 8;
  localparam int CH   = 4;
  localparam int CHW  = 3;
  localparam int SCYC = 2;

  typedef struct {
    logic [DATA-1:0] data;
    logic [CHW-1:0]  ch;
    int              cyc;
  } exp_t;

  logic Clock;
  logic Reset;
  sar_seq_ctrl_if #(.DATA(DATA), .CHW(CHW)) bus ();

  sar_seq_ctrl #(.DATA(DATA), .CH(CH), .CHW(CHW), .SAMPLE_CYC(SCYC)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  logic [DATA-1:0] ain [0:7];
  exp_t            sb [$];
  int              cyc = 0;
  int              vectors = 0;
  int              miscompares = 0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  // Ideal comparator: analog input of the selected channel vs DAC trial code.
  assign bus.Compare = (ain[bus.ChAddr] >= bus.DacCode);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [DATA-1:0] d, input logic [CHW-1:0] c, input int at);
    exp_t e;
    e.data = d;
    e.ch   = c;
    e.cyc  = at;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Monitor: every Valid strobe must match the head of the scoreboard.
  always @(negedge Clock) begin
    if (!Reset && bus.Valid) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_valid: got DataOut=0x%0h ChOut=%0d, expected no strobe (cycle %0d)",
                 bus.DataOut, bus.ChOut, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("valid_data",  32'(bus.DataOut), 32'(e.data));
        chk("valid_ch",    32'(bus.ChOut),   32'(e.ch));
        chk("valid_cycle", 32'(cyc),         32'(e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA-1:0] tr37 [0:7];
    logic [DATA-1:0] scanv [0:3];
    int c0;

    tr37  = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    scanv = '{8'h00, 8'hFF, 8'h80, 8'h7F};
    for (int i = 0; i < 8; i++) ain[i] = '0;

    Reset     = 1'b1;
    bus.Start = 1'b0;
    bus.Scan  = 1'b0;
    bus.ChSel = '0;
    bus.Abort = 1'b0;

    // Reset state
    #3;
    chk("rst_busy",     32'(bus.Busy),     32'd0);
    chk("rst_valid",    32'(bus.Valid),    32'd0);
    chk("rst_sampleen", 32'(bus.SampleEn), 32'd0);
    chk("rst_daccode",  32'(bus.DacCode),  32'd0);
    chk("rst_dataout",  32'(bus.DataOut),  32'd0);
    chk("rst_chaddr",   32'(bus.ChAddr),   32'd0);
    tick();
    Reset = 1'b0;
    tick();

    // Single conversion, channel 2, input 0xA5
    ain[2]    = 8'hA5;
    bus.ChSel = 3'd2;
    bus.Scan  = 1'b0;
    bus.Start = 1'b1;
    push(8'hA5, 3'd2, cyc + 11);
    tick();
    bus.Start = 1'b0;
    chk("single_chaddr",   32'(bus.ChAddr),   32'd2);
    chk("single_sampleen", 32'(bus.SampleEn), 32'd1);
    tick();
    tick();
    for (int k = 0; k < 8; k++) begin
      chk("single_trial", 32'(bus.DacCode), 32'(tr37[k]));
      tick();
    end
    tick();
    chk("single_idle", 32'(bus.Busy), 32'd0);

    // Full scan of four channels
    for (int i = 0; i < 4; i++) ain[i] = scanv[i];
    bus.Scan  = 1'b1;
    bus.ChSel = 3'd5;
    bus.Start = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 4; i++) push(scanv[i], CHW'(i), c0 + 11 * (i + 1));
    tick();
    bus.Start = 1'b0;
    bus.Scan  = 1'b0;
    repeat (43) tick();
    chk("scan_busy_last", 32'(bus.Busy), 32'd1);
    tick();
    chk("scan_idle", 32'(bus.Busy), 32'd0);

    // Abort in the 4th CONVERT cycle of channel 1
    ain[0]    = 8'h3C;
    ain[1]    = 8'h99;
    bus.Scan  = 1'b1;
    bus.Start = 1'b1;
    c0 = cyc;
    push(8'h3C, 3'd0, c0 + 11);
    tick();
    bus.Start = 1'b0;
    bus.Scan  = 1'b0;
    repeat (16) tick();
    chk("abort_trial4", 32'(bus.DacCode), 32'h90);
    bus.Abort = 1'b1;
    tick();
    bus.Abort = 1'b0;
    chk("abort_busy",    32'(bus.Busy),    32'd0);
    chk("abort_dataout", 32'(bus.DataOut), 32'h3C);
    chk("abort_chout",   32'(bus.ChOut),   32'd0);
    chk("abort_daccode", 32'(bus.DacCode), 32'd0);
    repeat (30) tick();

    // Abort together with Start in IDLE wins
    bus.Start = 1'b1;
    bus.Abort = 1'b1;
    tick();
    bus.Start = 1'b0;
    bus.Abort = 1'b0;
    chk("abort_start_idle", 32'(bus.Busy), 32'd0);

    // Start held high while busy, then one more Start after DONE
    ain[1]    = 8'h5A;
    ain[3]    = 8'h01;
    bus.ChSel = 3'd1;
    bus.Start = 1'b1;
    c0 = cyc;
    push(8'h5A, 3'd1, c0 + 11);
    tick();
    bus.ChSel = 3'd3;
    repeat (11) tick();
    push(8'h01, 3'd3, cyc + 11);
    tick();
    bus.Start = 1'b0;
    repeat (12) tick();
    chk("restart_idle",  32'(bus.Busy),    32'd0);
    chk("restart_data",  32'(bus.DataOut), 32'h01);

    // Reset in SAMPLE, out-of-range ChSel clamps to CH-1
    ain[3]    = 8'h42;
    bus.ChSel = 3'd7;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    chk("clamp_chaddr", 32'(bus.ChAddr), 32'd3);
    tick();
    Reset = 1'b1;
    #1;
    chk("rst_sample_busy",     32'(bus.Busy),     32'd0);
    chk("rst_sample_sampleen", 32'(bus.SampleEn), 32'd0);
    chk("rst_sample_chaddr",   32'(bus.ChAddr),   32'd0);
    chk("rst_sample_dataout",  32'(bus.DataOut),  32'd0);
    chk("rst_sample_chout",    32'(bus.ChOut),    32'd0);
    #1;
    Reset = 1'b0;

    // Reset in CONVERT
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    repeat (4) tick();
    chk("conv_trial3", 32'(bus.DacCode), 32'h60);
    Reset = 1'b1;
    #1;
    chk("rst_conv_busy",    32'(bus.Busy),    32'd0);
    chk("rst_conv_daccode", 32'(bus.DacCode), 32'd0);
    chk("rst_conv_valid",   32'(bus.Valid),   32'd0);
    #1;
    Reset = 1'b0;

    // Fresh conversion after reset
    bus.Start = 1'b1;
    push(8'h42, 3'd3, cyc + 11);
    tick();
    bus.Start = 1'b0;
    repeat (12) tick();
    chk("post_rst_idle", 32'(bus.Busy), 32'd0);

    repeat (3) tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
